mult_shift_add: RTL and testbench

- Sequential unsigned shift-and-add multiplier that consumes the combinational adder_N ripple-carry adder.
- Each cycle, adder_N adds the multiplicand to the upper half of a product register, then the carry-out and sum are shifted right one bit.
- An N x N product completes in N iterations behind a start/busy/done handshake.
- Sits downstream of the adder stage; serves as the next arithmetic building block after addition.

---
 rtl/mult_pkg.sv | 17 +
 rtl/adder_N.sv | 35 +++
 rtl/mult_shift_add.sv | 102 ++++++++++
 tb/tb_mult_shift_add.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    // Width of the iteration counter, wide enough to hold 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder_N.sv
// Combinational N-bit ripple-carry adder: {cout, sum} = a + b + cin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   a, b  N-bit addends
//   cin   carry in
//   sum   N-bit sum
//   cout  carry out of the top bit
module adder_N #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // carry[i] is the carry into bit i; carry[N] is the final carry out.
    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    assign cout = carry[N];

endmodule

// File: rtl/mult_shift_add.sv
// Sequential unsigned N x N shift-and-add multiplier (one adder_N, one bit per cycle).
// Latency: start sampled at edge k -> done high in the cycle after edge k+N+1.
// Backpressure: start is ignored while busy; a new op is accepted at edge k+N+2 earliest.
//
// Ports:
//   CLK      rising-edge clock
//   n_RESET  asynchronous active-low reset
//   start    request a multiply (sampled in IDLE only)
//   A, B     multiplicand / multiplier, captured on the accepted start edge
//   busy     high from the start edge until the end of the done cycle
//   done     one-cycle pulse, P valid from this cycle onward
//   P        2N-bit product, held until the next result is ready
module mult_shift_add
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             CLK,
    input  logic             n_RESET,
    input  logic             start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   P
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mult_state_t     state;
    logic [CW-1:0]   count;
    logic [N-1:0]    mcand;
    // Upper half accumulates partial sums; lower half holds the multiplier
    // bits still to be consumed, LSB first.
    logic [2*N-1:0]  prod;

    logic [N-1:0]    addend;
    logic [N-1:0]    sum;
    logic            cout;
    logic [2*N-1:0]  prod_next;

    assign addend = prod[0] ? mcand : '0;

    adder_N #(.N(N)) u_adder (
        .a    (prod[2*N-1:N]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Carry lands in the top bit so the shifted accumulator never loses it.
    assign prod_next = {cout, sum, prod[N-1:1]};

    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
            count <= '0;
            mcand <= '0;
            prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Entering IDLE from DONE leaves busy high for the done
                    // cycle; it falls here unless a new op is accepted.
                    done <= 1'b0;
                    if (start) begin
                        mcand <= A;
                        prod  <= {{N{1'b0}}, B};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    prod  <= prod_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        P     <= prod_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // done is registered, so the pulse appears in the cycle
                    // after this state while busy is still held high.
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_shift_add.sv
module tb_mult_shift_add;

    localparam int N = 4;

    logic           CLK;
    logic           n_RESET;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*N-1:0] P;

    int checks = 0;
    int errors = 0;

    mult_shift_add #(.N(N)) dut (
        .CLK     (CLK),
        .n_RESET (n_RESET),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .P       (P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse start for one edge, scramble A/B afterwards, wait (bounded) for
    // done, then sample the cycle after done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [2*N-1:0] p, output int lat,
                          output logic busy_early, output logic done_after,
                          output logic busy_after);
        @(negedge CLK);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge CLK);
        #1;
        busy_early = busy;
        start = 1'b0;
        A = ~a;
        B = ~b;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        p = P;
        @(posedge CLK);
        #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        n_RESET = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b P=%h, want 0 0 00", busy, done, P);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_RESET = 1'b1;
    endtask

    task automatic test_single_op();
        logic [2*N-1:0] p;
        int lat;
        logic be, da, ba;
        run_op(4'd3, 4'd5, p, lat, be, da, ba);
        checks++;
        if (be !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_rise: busy=%b want 1", be);
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL single_latency: got %0d want 5", lat);
        end
        checks++;
        if (p !== 8'd15) begin
            errors++;
            $display("FAIL single_product: P=%0d want 15", p);
        end
        checks++;
        if (da !== 1'b0 || ba !== 1'b0) begin
            errors++;
            $display("FAIL single_after_done: done=%b busy=%b want 0 0", da, ba);
        end
    endtask

    task automatic test_max_operands();
        logic [2*N-1:0] p;
        int lat;
        logic be, da, ba;
        run_op(4'd15, 4'd15, p, lat, be, da, ba);
        checks++;
        if (p !== 8'hE1) begin
            errors++;
            $display("FAIL max_product: P=%h want e1", p);
        end
        checks++;
        if (da !== 1'b0) begin
            errors++;
            $display("FAIL max_done_width: done=%b one cycle later, want 0", da);
        end
    endtask

    task automatic test_zero_operands();
        logic [2*N-1:0] p;
        int lat;
        logic be, da, ba;
        run_op(4'd0, 4'd9, p, lat, be, da, ba);
        checks++;
        if (p !== 8'd0 || lat != 5) begin
            errors++;
            $display("FAIL zero_a: P=%0d lat=%0d want 0 5", p, lat);
        end
        run_op(4'd9, 4'd0, p, lat, be, da, ba);
        checks++;
        if (p !== 8'd0 || lat != 5) begin
            errors++;
            $display("FAIL zero_b: P=%0d lat=%0d want 0 5", p, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge CLK);
        A = 4'd7;
        B = 4'd6;
        start = 1'b1;
        @(posedge CLK);
        #1;
        // Operands changed during RUN, start kept high.
        A = 4'd2;
        B = 4'd3;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            @(posedge CLK);
            #1;
            checks++;
            if (done !== 1'b1 && busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy_hold: busy=%b want 1 at cycle %0d", busy, lat + 1);
            end
            lat++;
        end
        checks++;
        if (lat != 5 || P !== 8'd42) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d P=%0d want 5 42", lat, P);
        end
        // Edge right after the done cycle must accept the held start.
        @(posedge CLK);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || P !== 8'd42) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b P=%0d want 1 0 42", busy, done, P);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        checks++;
        if (lat != 5 || P !== 8'd6) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d P=%0d want 5 6", lat, P);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [2*N-1:0] p;
        int lat;
        logic be, da, ba;
        logic seen_done;
        @(negedge CLK);
        A = 4'd12;
        B = 4'd11;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(posedge CLK);
        #2;
        n_RESET = 1'b0;
        #1;
        checks++;
        if (P !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: P=%0d busy=%b done=%b want 0 0 0", P, busy, done);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_RESET = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(posedge CLK);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_done: activity seen=%b want 0", seen_done);
        end
        run_op(4'd12, 4'd11, p, lat, be, da, ba);
        checks++;
        if (p !== 8'd132 || lat != 5) begin
            errors++;
            $display("FAIL midreset_rerun: P=%0d lat=%0d want 132 5", p, lat);
        end
    endtask

    task automatic test_exhaustive();
        logic [2*N-1:0] p;
        logic [2*N-1:0] want;
        int lat;
        logic be, da, ba;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                want = 8'(a * b);
                run_op(4'(a), 4'(b), p, lat, be, da, ba);
                checks++;
                if (p !== want || lat != 5) begin
                    errors++;
                    $display("FAIL exh_product a=%0d b=%0d: P=%0d lat=%0d want %0d 5", a, b, p, lat, want);
                end
                checks++;
                if (da !== 1'b0 || ba !== 1'b0) begin
                    errors++;
                    $display("FAIL exh_pulse a=%0d b=%0d: done=%b busy=%b after done, want 0 0", a, b, da, ba);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_max_operands();
        test_zero_operands();
        test_back_to_back();
        test_reset_mid_op();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
